// File: rtl/adder_sched_pkg.sv
// adder_sched_pkg: shared widths, FSM state, result tag and round-robin helper for adder_pkt_sched
package adder_sched_pkg;
  localparam int BEAT_W   = 16;
  localparam int OPND_W   = 8;
  localparam int TAG_ID_W = 3;
  typedef enum logic {IDLE, XMIT} state_t;
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
    logic                last;
  } tag_t;
  function automatic int rr_next(input int cur, input int n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction
endpackage

// File: rtl/adder_tag_pipe.sv
// adder_tag_pipe: delays beat tags by ADD_LATENCY cycles and pairs them with the captured adder sum
//   clk, reset   : clock, async active-high reset
//   i_tag        : tag of the beat driven this cycle
//   i_res        : adder sum (valid ADD_LATENCY cycles after its beat)
//   o_tag/o_data : registered tagged result
//   o_inflight   : any tag still in the line or on the output
module adder_tag_pipe
  import adder_sched_pkg::*;
#(
  parameter int ADD_LATENCY = 1
)(
  input  logic              clk,
  input  logic              reset,
  input  tag_t              i_tag,
  input  logic [OPND_W-1:0] i_res,
  output tag_t              o_tag,
  output logic [OPND_W-1:0] o_data,
  output logic              o_inflight
);
  tag_t w_tail;
  tag_t r_tag;
  logic [OPND_W-1:0] r_data;
  logic w_line_busy;
  if (ADD_LATENCY == 0) begin : g_direct
    assign w_tail = i_tag;
    assign w_line_busy = 1'b0;
  end else begin : g_line
    tag_t r_line [ADD_LATENCY];
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        for (int i = 0; i < ADD_LATENCY; i++) r_line[i] <= '0;
      end else begin
        r_line[0] <= i_tag;
        for (int i = 1; i < ADD_LATENCY; i++) r_line[i] <= r_line[i-1];
      end
    always_comb begin
      w_line_busy = 1'b0;
      for (int i = 0; i < ADD_LATENCY; i++) w_line_busy = w_line_busy | r_line[i].valid;
    end
    assign w_tail = r_line[ADD_LATENCY-1];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_tag  <= '0;
      r_data <= '0;
    end else begin
      r_tag  <= w_tail.valid ? w_tail : '0;
      r_data <= w_tail.valid ? i_res : '0;
    end
  assign o_tag      = r_tag;
  assign o_data     = r_data;
  assign o_inflight = w_line_busy | r_tag.valid;
endmodule

// File: rtl/adder_pkt_sched.sv
// adder_pkt_sched: round-robin packet scheduler serialising operand packets into the 8-bit adder
//   req_valid/req_ready/req_data : per-requester packet offer, one-hot accept pulse, packed packets
//   op_a_o/op_b_o/op_valid_o     : operand beat to the adder
//   res_i                        : adder sum
//   res_valid_o/res_data_o/res_id_o/res_last_o : tagged result stream
//   busy_o, pkt_cnt_o            : activity flag, completed packet counter
module adder_pkt_sched
  import adder_sched_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int PACKAGE_WIDTH = 1600,
  parameter int BEATS         = 100,
  parameter int ADD_LATENCY   = 1,
  parameter int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)(
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*PACKAGE_WIDTH-1:0] req_data,
  output logic [OPND_W-1:0]                op_a_o,
  output logic [OPND_W-1:0]                op_b_o,
  output logic                             op_valid_o,
  input  logic [OPND_W-1:0]                res_i,
  output logic                             res_valid_o,
  output logic [OPND_W-1:0]                res_data_o,
  output logic [ID_W-1:0]                  res_id_o,
  output logic                             res_last_o,
  output logic                             busy_o,
  output logic [15:0]                      pkt_cnt_o
);
  localparam int SR_W  = BEATS * BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  if (SR_W > PACKAGE_WIDTH) begin : g_chk
    $error("adder_pkt_sched: BEATS*16 exceeds PACKAGE_WIDTH");
  end
  state_t r_state;
  logic [ID_W-1:0] r_ptr, r_id, w_gnt_id, w_idx;
  logic [CNT_W-1:0] r_beat;
  logic [SR_W-1:0] r_sr, w_slice;
  logic [OPND_W-1:0] r_op_a, r_op_b;
  logic [15:0] r_pkt_cnt;
  logic w_gnt_any, w_last, w_pipe_busy;
  logic [TAG_ID_W-1:0] w_unused_id;
  tag_t w_tag_in, w_tag_out;
  // Scan offsets high to low so the nearest valid requester at/after the pointer wins.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    w_idx     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = ID_W'((int'(r_ptr) + i) % NUM_REQ);
      if (req_valid[w_idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = w_idx;
      end
    end
  end
  always_comb begin
    w_slice = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (w_gnt_id == ID_W'(i)) w_slice = req_data[i*PACKAGE_WIDTH +: SR_W];
  end
  // Accept is combinational so the handshake cycle itself is the grant cycle; reset masks it.
  assign req_ready = (r_state == IDLE && w_gnt_any && !reset) ? NUM_REQ'(1) << w_gnt_id : '0;
  assign w_last = r_beat == CNT_W'(BEATS - 1);
  // The grant edge already loads beat 0 onto the operand registers; r_sr holds the remaining beats.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_id      <= '0;
      r_beat    <= '0;
      r_sr      <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_pkt_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (w_gnt_any) begin
        r_state          <= XMIT;
        r_id             <= w_gnt_id;
        r_ptr            <= ID_W'(rr_next(int'(w_gnt_id), NUM_REQ));
        r_beat           <= '0;
        {r_op_b, r_op_a} <= w_slice[BEAT_W-1:0];
        r_sr             <= w_slice >> BEAT_W;
      end
    end else if (w_last) begin
      r_state          <= IDLE;
      r_beat           <= '0;
      {r_op_b, r_op_a} <= '0;
      r_pkt_cnt        <= r_pkt_cnt + 16'd1;
    end else begin
      r_beat           <= r_beat + 1'b1;
      {r_op_b, r_op_a} <= r_sr[BEAT_W-1:0];
      r_sr             <= r_sr >> BEAT_W;
    end
  assign w_tag_in = '{valid: r_state == XMIT, id: TAG_ID_W'(r_id), last: r_state == XMIT && w_last};
  adder_tag_pipe #(.ADD_LATENCY(ADD_LATENCY)) u_tag_pipe (
    .clk        (clk),
    .reset      (reset),
    .i_tag      (w_tag_in),
    .i_res      (res_i),
    .o_tag      (w_tag_out),
    .o_data     (res_data_o),
    .o_inflight (w_pipe_busy)
  );
  assign w_unused_id = w_tag_out.id;
  assign op_a_o      = r_op_a;
  assign op_b_o      = r_op_b;
  assign op_valid_o  = r_state == XMIT;
  assign res_valid_o = w_tag_out.valid;
  assign res_id_o    = w_unused_id[ID_W-1:0];
  assign res_last_o  = w_tag_out.last;
  assign busy_o      = op_valid_o | w_pipe_busy;
  assign pkt_cnt_o   = r_pkt_cnt;
endmodule
